// File: rtl/cpu_defs.sv
// Shared encodings for the control sequencer: opcodes, states, ALU codes, IR fields.
// Pure definitions; no timing or flow control.
package cpu_defs;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_HALT = 4'd7
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SHR  = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;

  localparam int IR_OP_MSB = 31;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_LSB = 15;

  // Non-zero result doubles as the "register-register ALU instruction" test.
  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SHR:  return ALU_SHR;
      OP_SHL:  return ALU_SHL;
      OP_ROR:  return ALU_ROR;
      OP_ROL:  return ALU_ROL;
      default: return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_decode.sv
// 4-bit register field to one-hot enable, gated by i_en.
// Combinational, no latency, no flow control.
module reg_select_decode
  import cpu_defs::*;
#(
  parameter int NREG = 16
) (
  input  logic [3:0]      i_sel,
  input  logic            i_en,
  output logic [NREG-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit driving Datapath strobes through fetch (T0-T2) and ALU execute (T3-T5).
// 6 cycles per ALU instruction; MemReady low holds T1, Run only sampled at instruction boundaries.
module control_sequencer
  import cpu_defs::*;
#(
  parameter int NREG = 16,
  parameter int OPW  = 5
) (
  input  logic            Clock,
  input  logic            Clear_n,
  input  logic            Run,
  input  logic            MemReady,
  input  logic [31:0]     IR,
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            MARin,
  output logic            Zin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            IncPC,
  output logic            Read,
  output logic [NREG-1:0] RegIn,
  output logic [NREG-1:0] RegOut,
  output logic [3:0]      AluOp,
  output logic            Halted,
  output logic            IllegalOp
);

  state_t           r_state;
  state_t           w_next;
  logic             r_t1_wait;
  logic             r_illegal;
  logic             w_set_illegal;

  logic [OPW-1:0]   w_opcode;
  logic [3:0]       w_ra, w_rb, w_rc;
  logic [3:0]       w_alu;
  logic             w_is_alu;
  logic [3:0]       w_out_sel;
  logic             w_out_en;
  logic             w_in_en;
  logic             w_unused;

  assign w_opcode = IR[IR_OP_MSB -: OPW];
  assign w_ra     = IR[IR_RA_LSB +: 4];
  assign w_rb     = IR[IR_RB_LSB +: 4];
  assign w_rc     = IR[IR_RC_LSB +: 4];
  assign w_alu    = alu_code(w_opcode);
  assign w_is_alu = (w_alu != ALU_NONE);
  assign w_unused = ^IR[IR_RC_LSB-1:0];

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      r_state   <= S_IDLE;
      r_t1_wait <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      // Marks the repeat T1 cycles so PCin is not re-asserted while waiting on memory.
      r_t1_wait <= (r_state == S_T1) && !MemReady;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    PCout         = 1'b0;
    Zlowout       = 1'b0;
    MDRout        = 1'b0;
    MARin         = 1'b0;
    Zin           = 1'b0;
    PCin          = 1'b0;
    MDRin         = 1'b0;
    IRin          = 1'b0;
    Yin           = 1'b0;
    IncPC         = 1'b0;
    Read          = 1'b0;
    AluOp         = ALU_NONE;
    Halted        = 1'b0;
    w_out_sel     = w_rb;
    w_out_en      = 1'b0;
    w_in_en       = 1'b0;
    case (r_state)
      S_IDLE: if (Run) w_next = S_T0;
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zin    = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = !r_t1_wait;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (MemReady) w_next = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        w_next = S_T3;
      end
      S_T3: begin
        if (w_is_alu) begin
          w_out_en = 1'b1;
          Yin      = 1'b1;
          w_next   = S_T4;
        end else if (w_opcode == OP_HALT) begin
          w_next = S_HALT;
        end else begin
          w_set_illegal = (w_opcode != OP_NOP);
          w_next        = Run ? S_T0 : S_IDLE;
        end
      end
      S_T4: begin
        w_out_sel = w_rc;
        w_out_en  = 1'b1;
        AluOp     = w_alu;
        Zin       = 1'b1;
        w_next    = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        w_in_en = 1'b1;
        w_next  = Run ? S_T0 : S_IDLE;
      end
      S_HALT: Halted = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  assign IllegalOp = r_illegal;

  reg_select_decode #(.NREG(NREG)) u_regout_dec (
    .i_sel    (w_out_sel),
    .i_en     (w_out_en),
    .o_onehot (RegOut)
  );

  reg_select_decode #(.NREG(NREG)) u_regin_dec (
    .i_sel    (w_ra),
    .i_en     (w_in_en),
    .o_onehot (RegIn)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed literal checks plus randomized instruction streams
// expanded into per-cycle expectations by an instruction-level model.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear_n, Run, MemReady;
  logic [31:0] IR;
  logic        PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic [15:0] RegIn, RegOut;
  logic [3:0]  AluOp;
  logic        Halted, IllegalOp;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  control_sequencer #(.NREG(16), .OPW(5)) dut (
    .Clock(Clock), .Clear_n(Clear_n), .Run(Run), .MemReady(MemReady), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
    .RegIn(RegIn), .RegOut(RegOut), .AluOp(AluOp), .Halted(Halted), .IllegalOp(IllegalOp)
  );

  localparam int B_PCOUT = 10, B_ZLOW = 9, B_MDROUT = 8, B_MARIN = 7, B_ZIN = 6, B_PCIN = 5;
  localparam int B_MDRIN = 4, B_IRIN = 3, B_YIN = 2, B_INCPC = 1, B_READ = 0;

  typedef struct {
    logic [10:0] stb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [3:0]  alu;
    logic        hlt;
    logic        ill;
    logic        run;
    logic        mrdy;
    logic [31:0] ir;
  } cyc_t;

  cyc_t q[$];
  logic m_ill;

  function automatic logic [10:0] strobes();
    return {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bus-drive exclusivity and one-hot register enables, every live cycle.
  always @(negedge Clock) begin
    if (Clear_n === 1'b1) begin
      int drivers;
      drivers = int'(PCout) + int'(Zlowout) + int'(MDRout) + int'(|RegOut);
      checks++;
      if (drivers > 1 || $countones(RegOut) > 1 || $countones(RegIn) > 1 || ((|RegIn) && (|RegOut))) begin
        errors++;
        $display("FAIL excl: drivers=%0d RegIn=%h RegOut=%h at %0t", drivers, RegIn, RegOut, $time);
      end
    end
  end

  function automatic logic [3:0] spec_alu(input logic [4:0] op);
    case (op)
      5'b00011: return 4'd1;
      5'b00100: return 4'd2;
      5'b00101: return 4'd3;
      5'b00110: return 4'd4;
      5'b00111: return 4'd5;
      5'b01001: return 4'd6;
      5'b01010: return 4'd7;
      5'b01011: return 4'd8;
      default:  return 4'd0;
    endcase
  endfunction

  function automatic cyc_t blank(input logic [31:0] ir, input logic run, input logic mrdy);
    cyc_t c;
    c.stb = '0; c.rin = '0; c.rout = '0; c.alu = '0; c.hlt = 1'b0;
    c.ill = m_ill; c.run = run; c.mrdy = mrdy; c.ir = ir;
    return c;
  endfunction

  task automatic push_idle(input logic run);
    q.push_back(blank($urandom, run, 1'($urandom)));
  endtask

  // Expand one instruction into the cycles it must occupy and what each cycle shows.
  task automatic plan_instr(input logic [31:0] ir, input int waits, input bit run_end);
    cyc_t c;
    logic [15:0] one;
    logic [4:0] op;
    one = 16'h0001;
    op = ir[31:27];
    c = blank(ir, 1'($urandom), 1'($urandom));
    c.stb[B_PCOUT] = 1; c.stb[B_MARIN] = 1; c.stb[B_INCPC] = 1; c.stb[B_ZIN] = 1;
    q.push_back(c);
    for (int i = 0; i <= waits; i++) begin
      c = blank(ir, 1'($urandom), (i == waits));
      c.stb[B_ZLOW] = 1; c.stb[B_READ] = 1; c.stb[B_MDRIN] = 1; c.stb[B_PCIN] = (i == 0);
      q.push_back(c);
    end
    c = blank(ir, 1'($urandom), 1'($urandom));
    c.stb[B_MDROUT] = 1; c.stb[B_IRIN] = 1;
    q.push_back(c);
    if (spec_alu(op) != 0) begin
      c = blank(ir, 1'($urandom), 1'($urandom));
      c.stb[B_YIN] = 1; c.rout = one << ir[22:19];
      q.push_back(c);
      c = blank(ir, 1'($urandom), 1'($urandom));
      c.stb[B_ZIN] = 1; c.rout = one << ir[18:15]; c.alu = spec_alu(op);
      q.push_back(c);
      c = blank(ir, run_end, 1'($urandom));
      c.stb[B_ZLOW] = 1; c.rin = one << ir[26:23];
      q.push_back(c);
    end else if (op == 5'b11011) begin
      q.push_back(blank(ir, 1'($urandom), 1'($urandom)));
      for (int i = 0; i < 3; i++) begin
        c = blank($urandom, 1'($urandom), 1'($urandom));
        c.hlt = 1;
        q.push_back(c);
      end
      return;
    end else begin
      q.push_back(blank(ir, run_end, 1'($urandom)));
      if (op != 5'b11010) m_ill = 1'b1;
    end
    if (!run_end) begin
      int n;
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) push_idle(1'b0);
      push_idle(1'b1);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] op;
    logic [4:0] alus[8];
    int k;
    alus = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01001, 5'b01010, 5'b01011};
    k = $urandom_range(0, 9);
    if (k < 8) op = alus[$urandom_range(0, 7)];
    else if (k == 8) op = 5'b11010;
    else begin
      op = 5'b11111;
      for (int t = 0; t < 8; t++) begin
        op = 5'($urandom);
        if (spec_alu(op) == 0 && op != 5'b11010 && op != 5'b11011) break;
        op = 5'b11111;
      end
    end
    return {op, 27'($urandom)};
  endfunction

  // Entered #1 after a rising edge with reset just released; leaves at the same phase.
  task automatic run_queue();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      Run = c.run; MemReady = c.mrdy; IR = c.ir;
      @(negedge Clock);
      checks++;
      if ({strobes(), RegIn, RegOut, AluOp, Halted, IllegalOp} !== {c.stb, c.rin, c.rout, c.alu, c.hlt, c.ill}) begin
        errors++;
        $display("FAIL cyc@%0t: stb=%b rin=%h rout=%h alu=%0d hlt=%b ill=%b exp stb=%b rin=%h rout=%h alu=%0d hlt=%b ill=%b",
                 $time, strobes(), RegIn, RegOut, AluOp, Halted, IllegalOp,
                 c.stb, c.rin, c.rout, c.alu, c.hlt, c.ill);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic do_reset();
    Clear_n = 1'b0; Run = 1'b0; MemReady = 1'b0;
    @(posedge Clock); #1;
    Clear_n = 1'b1;
    m_ill = 1'b0;
  endtask

  task automatic step();
    @(posedge Clock); @(negedge Clock);
  endtask

  initial begin
    Clear_n = 1'b0; Run = 1'b0; MemReady = 1'b0; IR = '0; m_ill = 1'b0;
    repeat (2) @(posedge Clock);
    #2;
    chk("rst_strobes", 32'(strobes()), 32'h0);
    chk("rst_regs", {RegIn, RegOut}, 32'h0);
    chk("rst_flags", {AluOp, Halted, IllegalOp}, 32'h0);
    @(posedge Clock); #1;
    Clear_n = 1'b1; Run = 1'b1; MemReady = 1'b1; IR = 32'h28918000;
    step();
    chk("t0_strobes", 32'(strobes()), 32'h000004C2);
    step(); step(); step();
    chk("t3_regout", 32'(RegOut), 32'h0004);
    chk("t3_yin", 32'(Yin), 32'h1);
    step();
    chk("t4_regout", 32'(RegOut), 32'h0008);
    chk("t4_aluop", 32'(AluOp), 32'h3);
    chk("t4_zin", 32'(Zin), 32'h1);
    step();
    chk("t5_regin", 32'(RegIn), 32'h0002);
    chk("t5_zlowout", 32'(Zlowout), 32'h1);
    step();
    chk("next_t0_pcout", 32'(PCout), 32'h1);
    step(); step(); step();
    @(posedge Clock); #2;
    chk("pre_rst_aluop", 32'(AluOp), 32'h3);
    #1 Clear_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {strobes(), RegIn[0], RegOut[0], AluOp, Halted, IllegalOp}, 32'h0);
    chk("mid_rst_regs", {RegIn, RegOut}, 32'h0);
    Run = 1'b0;
    @(posedge Clock); #1;
    Clear_n = 1'b1;
    @(negedge Clock);
    chk("idle_after_rst", {strobes(), AluOp, Halted, IllegalOp}, 32'h0);
    @(posedge Clock); #1;

    // Directed stream: ror with two wait states, add with Run dropped, illegal, halt.
    m_ill = 1'b0;
    push_idle(1'b1);
    plan_instr(32'h53320000, 2, 1'b1);
    plan_instr(32'h18918000, 0, 1'b0);
    plan_instr(32'hF8918000, 0, 1'b1);
    plan_instr(32'hD8000000, 0, 1'b1);
    run_queue();

    for (int b = 0; b < 3; b++) begin
      do_reset();
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) push_idle(1'b0);
      push_idle(1'b1);
      for (int i = 0; i < 12; i++)
        plan_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3) != 0);
      plan_instr({5'b11011, 27'($urandom)}, $urandom_range(0, 3), 1'b1);
      run_queue();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardware control unit that generates the datapath strobes (PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, per-register in/out enables, ALU op select) for fetch and register-register ALU execution.
- Replaces the hand-sequenced stimulus currently used to drive Datapath.
- Sits beside Datapath, reads the latched IR, and walks T0..T5 per instruction with a memory-ready handshake on fetch.

Parameters:
- NREG, 16, number of general registers (one-hot enable width)
- OPW, 5, opcode field width

Ports:
- Clock  in  1  system clock, all state changes on rising edge
- Clear_n  in  1  asynchronous active-low reset
- Run  in  1  1 = continue sequencing; 0 = stop at next instruction boundary
- MemReady  in  1  memory has valid Mdatain for the current Read
- IR  in  32  instruction register contents from Datapath
- PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read  out  1 each  datapath strobes
- RegIn  out  NREG  one-hot register load enable
- RegOut  out  NREG  one-hot register bus-drive enable
- AluOp  out  4  ALU operation select (0 = pass/none)
- Halted  out  1  high while in HALT state
- IllegalOp  out  1  sticky: unrecognised opcode decoded since reset

Behaviour:
- Reset (Clear_n low, async): state = IDLE; every output 0; IllegalOp cleared.
- Outputs are Moore: decoded from the registered state and IR only; each strobe is high for exactly the cycles spent in its state.
- IR fields: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15]. Example: IR = 32'h28918000 gives and R1,R2,R3.
- States and transitions:
  - IDLE: all outputs 0. Go to T0 when Run = 1.
  - T0: PCout, MARin, IncPC, Zin. Next state T1.
  - T1: Zlowout, PCin, Read, MDRin.
    - Read and MDRin stay high while MemReady = 0; state is held.
    - On a cycle with MemReady = 1, go to T2.
    - PCin pulses on the first T1 cycle only, so PC is never incremented twice.
  - T2: MDRout, IRin. Next state T3.
  - T3: decode. Opcode classes:
    - ALU3 (add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01001, ror 01010, rol 01011): RegOut = onehot(Rb), Yin. Next state T4.
    - nop 11010: next state is T0 if Run = 1, else IDLE.
    - halt 11011: go to HALT.
    - Anything else: set IllegalOp, treat as nop.
  - T4: RegOut = onehot(Rc), AluOp = code(opcode), Zin. Next state T5.
  - T5: Zlowout, RegIn = onehot(Ra). Next state is T0 if Run = 1, else IDLE.
  - HALT: Halted = 1; all strobes 0. Exit only by reset.
- Run is sampled only at instruction boundaries (T5, nop/illegal at T3, IDLE). Dropping Run mid-instruction does not abort the instruction.
- At most one RegOut bit and one RegIn bit is set in any cycle. They are never set in the same cycle.
- Bus-drive exclusivity: at most one of PCout, Zlowout, MDRout, |RegOut is high per cycle.
- AluOp codes: add 1, sub 2, and 3, or 4, shr 5, shl 6, ror 7, rol 8. AluOp is 0 outside T4.
- Reset asserted mid-instruction returns to IDLE with outputs 0 immediately; there is no partial writeback.
- Latency: 6 cycles per ALU3 instruction with zero wait states; each MemReady wait adds 1 cycle.

Decomposition:
- Shared package (cpu_defs):
  - opcode constants
  - state encoding (IDLE, T0..T5, HALT; 4-bit)
  - AluOp codes
  - IR field bit positions
- One sub-module, reg_select_decode: 4-bit field plus enable in, NREG one-hot out. It is instantiated twice, for RegIn and RegOut.

Test Plan:
- Reset mid-T4 (Clear_n low 3 ns after edge) -> all outputs 0 before the next edge; state IDLE; IllegalOp 0.
- Run=1, MemReady tied 1, IR=32'h28918000 -> strobes in order across 6 cycles:
  - T3: RegOut=16'h0004, Yin.
  - T4: RegOut=16'h0008, AluOp=3, Zin.
  - T5: RegIn=16'h0002, Zlowout.
  - Next cycle: T0.
- ror R6,R6,R4 (IR=32'h53320000), MemReady low for 2 cycles in T1 -> T1 lasts 3 cycles; PCin high first cycle only; Read/MDRin high all 3; T4 AluOp=7.
- Run dropped during T3 of an add -> instruction completes through T5, then IDLE. Run re-raised -> T0 on the next cycle.
- IR opcode 11111 -> IllegalOp=1 (sticky); no RegIn/Zin after T2; next T0. Subsequent halt (IR=32'hD8000000) -> HALT, Halted=1, stays until Clear_n.
- Every cycle of the above: assert bus-drive exclusivity and RegIn/RegOut one-hot-or-zero.
